multicycle_controller: RTL and testbench
========================================

Name: multicycle_controller

Overview:
- Moore FSM that sequences the 16-bit multicycle datapath through fetch, decode, execute, memory and writeback.
- Decodes the latched instruction fields and the PSR flags.
- Drives every mux select, register enable, write strobe and sign-extend mode of the datapath.
- Sits beside the datapath in the CPU top level; the datapath's alucontrol still derives the ALU op from op_code and op_ext.

Parameters:
- OPBITS, 4, width of the op_code, op_ext and cond fields
- PSRL, 5, PSR width; bits {N,Z,F,L,C} = [4:0]
- STBITS, 4, state register width

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high; forces state to FETCH
- op_code  in  OPBITS  instr[15:12]
- op_ext  in  OPBITS  instr[7:4]
- cond  in  OPBITS  instr[11:8], branch/jump condition code
- psr_out  in  PSRL  registered flags from the datapath
- pc_s  out  1  0=Rsrc, 1=alu_out
- mem_s  out  1  0=Rdest, 1=pc
- wd_s  out  2  0=imm_ext, 1=Rsrc, 2=mem_out, 3=alu_out
- alua_s  out  2  0=Rsrc, 1=pc, 2=imm_ext, 3=zero
- alub_s  out  2  0=Rdest, 1=imm_ext, 2=one
- inst_en, alu_out_en, mem_reg_en, pc_en, psr_en  out  1 each  register enables
- se_sign  out  1  1=sign-extend imm8, 0=zero-extend
- reg_wr  out  1  register-file write
- mem_we  out  1  memory write strobe
- halted  out  1  high in HALT
- state  out  STBITS  current state, for debug

Behaviour:
- Reset: state=FETCH, asynchronous. During reset all outputs are 0 except mem_s, inst_en, alua_s=1 and alub_s=2 (FETCH decode). Reset mid-instruction abandons it; no reg_wr or mem_we is issued afterwards.
- Output model: any output not listed for a state is 0. Outputs are a combinational function of state, op fields and psr_out.
- FETCH: mem_s=1, inst_en=1, alua_s=1, alub_s=2, alu_out_en=1 (alu_out<=pc+1). Next state is DECODE.
- DECODE: pc_en=1, pc_s=1 (pc<=pc+1). Next state is dispatched as follows:
  - op_code 0000 -> EXEC_R
  - op_code in {0001,0010,0011,0101,1001,1011,1101} -> EXEC_I
  - op_code 0100, op_ext 0000 -> LOAD
  - op_code 0100, op_ext 0100 -> STORE
  - op_code 0100, op_ext 1100 -> JUMP
  - op_code 0100, op_ext 0001 -> HALT
  - op_code 1100 -> BR_CALC
  - anything else -> FETCH (NOP)
- EXEC_R: alua_s=0, alub_s=0, alu_out_en=1, psr_en=1. If op_ext==1011 (CMP) -> FETCH, else -> WB_ALU.
- EXEC_I: alua_s=2, alub_s=0, alu_out_en=1, psr_en=1.
  - se_sign=1 for op_code 0101/1001/1011, 0 otherwise.
  - MOVI (1101): no ALU use; reg_wr=1, wd_s=0 -> FETCH.
  - CMPI (1011) -> FETCH.
  - All others -> WB_ALU.
- WB_ALU: reg_wr=1, wd_s=3 -> FETCH.
- LOAD: mem_s=0, mem_reg_en=1 -> LOAD_WB.
- LOAD_WB: reg_wr=1, wd_s=2 -> FETCH.
- STORE: mem_s=0, mem_we=1 for exactly one cycle -> FETCH.
- BR_CALC: alua_s=1, alub_s=1, se_sign=1, alu_out_en=1 (target = pc+1+disp8). If condition is true -> BR_TAKE, else -> FETCH.
- BR_TAKE: pc_en=1, pc_s=1 -> FETCH.
- JUMP: pc_s=0, pc_en=condition result -> FETCH.
- HALT: all enables 0, halted=1. Only reset leaves this state.
- Condition codes (N=psr[4], Z=[3], F=[2], L=[1], C=[0]):

  | cond | mnemonic | true when |
  |---|---|---|
  | 0000 | EQ | Z |
  | 0001 | NE | !Z |
  | 0010 | CS | C |
  | 0011 | CC | !C |
  | 0100 | HI | L |
  | 0101 | LS | !L |
  | 0110 | GT | N |
  | 0111 | LE | !N |
  | 1000 | FS | F |
  | 1001 | FC | !F |
  | 1110 | UC | always |
  | all others | — | false |

  psr_out is sampled in the BR_CALC/JUMP cycle.
- Cycle counts:
  - ALU reg-write: 4
  - CMP/CMPI: 3
  - MOVI: 3
  - LOAD: 4
  - STORE: 3
  - branch taken: 4
  - branch not taken: 3
  - jump: 3
  - NOP: 2
- Invariants:
  - reg_wr and mem_we are never high in the same cycle.
  - pc_en is never high outside DECODE, BR_TAKE and JUMP.
  - Undefined state encodings recover to FETCH on the next clock.

Decomposition:
- Package ctrl_pkg holds:
  - state encodings: FETCH=0, DECODE=1, EXEC_R=2, EXEC_I=3, WB_ALU=4, LOAD=5, LOAD_WB=6, STORE=7, BR_CALC=8, BR_TAKE=9, JUMP=10, HALT=11
  - opcode/op_ext constants
  - condition-code constants
  - mux-select constants (WD_IMM, WD_RSRC, WD_MEM, WD_ALU, ALUA_PC, ALUB_ONE, ...)
- One sub-module: cond_eval (cond, psr_out -> taken), combinational, unit-testable on its own.

Test Plan:
- Reset then ADD (op 0000, ext 0101):
  - states are FETCH, DECODE, EXEC_R, WB_ALU, FETCH.
  - reg_wr=1 with wd_s=3 only in cycle 4; pc_en only in cycle 2.
- CMP (ext 1011), then CMPI (1011):
  - each takes 3 cycles with psr_en=1 in cycle 3.
  - reg_wr never asserted; CMPI has se_sign=1.
- LOAD then STORE:
  - LOAD asserts mem_s=0 with mem_reg_en in cycle 3, then reg_wr with wd_s=2 in cycle 4.
  - STORE asserts mem_we=1 for exactly one cycle with mem_s=0.
- Bcond EQ with psr_out=5'b01000:
  - BR_CALC then BR_TAKE with pc_en=1, pc_s=1.
  - With psr_out=0: BR_CALC then FETCH, no pc_en.
  - cond 1110 is always taken; cond 1111 is never taken.
- JUMP cond NE with Z=1: pc_en=0. With Z=0: pc_en=1, pc_s=0.
- HALT (0100/0001):
  - halted=1 and state holds for 20 cycles with all enables 0.
  - Asserting reset mid-LOAD_WB: next state FETCH, no reg_wr after reset.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle controller: states, opcode fields,
// condition codes and datapath mux selects.
package ctrl_pkg;

  typedef enum logic [3:0] {
    StFetch  = 4'd0,
    StDecode = 4'd1,
    StExecR  = 4'd2,
    StExecI  = 4'd3,
    StWbAlu  = 4'd4,
    StLoad   = 4'd5,
    StLoadWb = 4'd6,
    StStore  = 4'd7,
    StBrCalc = 4'd8,
    StBrTake = 4'd9,
    StJump   = 4'd10,
    StHalt   = 4'd11
  } state_t;

  localparam logic [3:0] OP_RTYPE   = 4'b0000;
  localparam logic [3:0] OP_ANDI    = 4'b0001;
  localparam logic [3:0] OP_ORI     = 4'b0010;
  localparam logic [3:0] OP_XORI    = 4'b0011;
  localparam logic [3:0] OP_SPECIAL = 4'b0100;
  localparam logic [3:0] OP_ADDI    = 4'b0101;
  localparam logic [3:0] OP_SUBI    = 4'b1001;
  localparam logic [3:0] OP_CMPI    = 4'b1011;
  localparam logic [3:0] OP_BCOND   = 4'b1100;
  localparam logic [3:0] OP_MOVI    = 4'b1101;

  localparam logic [3:0] EXT_LOAD  = 4'b0000;
  localparam logic [3:0] EXT_HALT  = 4'b0001;
  localparam logic [3:0] EXT_STORE = 4'b0100;
  localparam logic [3:0] EXT_CMP   = 4'b1011;
  localparam logic [3:0] EXT_JCOND = 4'b1100;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_HI = 4'b0100;
  localparam logic [3:0] COND_LS = 4'b0101;
  localparam logic [3:0] COND_GT = 4'b0110;
  localparam logic [3:0] COND_LE = 4'b0111;
  localparam logic [3:0] COND_FS = 4'b1000;
  localparam logic [3:0] COND_FC = 4'b1001;
  localparam logic [3:0] COND_UC = 4'b1110;

  localparam int unsigned PSR_N = 4;
  localparam int unsigned PSR_Z = 3;
  localparam int unsigned PSR_F = 2;
  localparam int unsigned PSR_L = 1;
  localparam int unsigned PSR_C = 0;

  localparam logic       PC_RSRC    = 1'b0;
  localparam logic       PC_ALU     = 1'b1;
  localparam logic       MEM_RDEST  = 1'b0;
  localparam logic       MEM_PC     = 1'b1;
  localparam logic [1:0] WD_IMM     = 2'd0;
  localparam logic [1:0] WD_RSRC    = 2'd1;
  localparam logic [1:0] WD_MEM     = 2'd2;
  localparam logic [1:0] WD_ALU     = 2'd3;
  localparam logic [1:0] ALUA_RSRC  = 2'd0;
  localparam logic [1:0] ALUA_PC    = 2'd1;
  localparam logic [1:0] ALUA_IMM   = 2'd2;
  localparam logic [1:0] ALUA_ZERO  = 2'd3;
  localparam logic [1:0] ALUB_RDEST = 2'd0;
  localparam logic [1:0] ALUB_IMM   = 2'd1;
  localparam logic [1:0] ALUB_ONE   = 2'd2;

  function automatic logic is_itype(input logic [3:0] op);
    return (op == OP_ANDI) || (op == OP_ORI) || (op == OP_XORI) || (op == OP_ADDI) ||
           (op == OP_SUBI) || (op == OP_CMPI) || (op == OP_MOVI);
  endfunction

  function automatic logic is_signed_imm(input logic [3:0] op);
    return (op == OP_ADDI) || (op == OP_SUBI) || (op == OP_CMPI);
  endfunction

endpackage

// File: rtl/cond_eval.sv
// Evaluates a branch/jump condition code against the PSR flags.
module cond_eval
  import ctrl_pkg::*;
#(
  parameter int unsigned OPBITS = 4,
  parameter int unsigned PSRL   = 5
) (
  input  logic [OPBITS-1:0] cond,
  input  logic [PSRL-1:0]   psr_out,
  output logic              taken
);

  always_comb begin
    taken = 1'b0;
    case (cond)
      COND_EQ: taken = psr_out[PSR_Z];
      COND_NE: taken = ~psr_out[PSR_Z];
      COND_CS: taken = psr_out[PSR_C];
      COND_CC: taken = ~psr_out[PSR_C];
      COND_HI: taken = psr_out[PSR_L];
      COND_LS: taken = ~psr_out[PSR_L];
      COND_GT: taken = psr_out[PSR_N];
      COND_LE: taken = ~psr_out[PSR_N];
      COND_FS: taken = psr_out[PSR_F];
      COND_FC: taken = ~psr_out[PSR_F];
      COND_UC: taken = 1'b1;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Moore FSM sequencing the 16-bit multicycle datapath through
// fetch/decode/execute/memory/writeback.
module multicycle_controller
  import ctrl_pkg::*;
#(
  parameter int unsigned OPBITS = 4,
  parameter int unsigned PSRL   = 5,
  parameter int unsigned STBITS = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [OPBITS-1:0] op_code,
  input  logic [OPBITS-1:0] op_ext,
  input  logic [OPBITS-1:0] cond,
  input  logic [PSRL-1:0]   psr_out,
  output logic              pc_s,
  output logic              mem_s,
  output logic [1:0]        wd_s,
  output logic [1:0]        alua_s,
  output logic [1:0]        alub_s,
  output logic              inst_en,
  output logic              alu_out_en,
  output logic              mem_reg_en,
  output logic              pc_en,
  output logic              psr_en,
  output logic              se_sign,
  output logic              reg_wr,
  output logic              mem_we,
  output logic              halted,
  output logic [STBITS-1:0] state
);

  state_t state_q, state_d;
  logic   taken;

  cond_eval #(
    .OPBITS (OPBITS),
    .PSRL   (PSRL)
  ) u_cond_eval (
    .cond    (cond),
    .psr_out (psr_out),
    .taken   (taken)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StFetch;
    end else begin
      state_q <= state_d;
    end
  end

  assign state = STBITS'(state_q);

  always_comb begin
    state_d    = StFetch;
    pc_s       = 1'b0;
    mem_s      = 1'b0;
    wd_s       = WD_IMM;
    alua_s     = ALUA_RSRC;
    alub_s     = ALUB_RDEST;
    inst_en    = 1'b0;
    alu_out_en = 1'b0;
    mem_reg_en = 1'b0;
    pc_en      = 1'b0;
    psr_en     = 1'b0;
    se_sign    = 1'b0;
    reg_wr     = 1'b0;
    mem_we     = 1'b0;
    halted     = 1'b0;

    case (state_q)
      StFetch: begin
        mem_s      = MEM_PC;
        inst_en    = 1'b1;
        alua_s     = ALUA_PC;
        alub_s     = ALUB_ONE;
        // alu_out is not captured while reset is held.
        alu_out_en = ~reset;
        state_d    = StDecode;
      end
      StDecode: begin
        pc_en = 1'b1;
        pc_s  = PC_ALU;
        if (op_code == OP_RTYPE) begin
          state_d = StExecR;
        end else if (is_itype(op_code)) begin
          state_d = StExecI;
        end else if (op_code == OP_SPECIAL) begin
          case (op_ext)
            EXT_LOAD:  state_d = StLoad;
            EXT_STORE: state_d = StStore;
            EXT_JCOND: state_d = StJump;
            EXT_HALT:  state_d = StHalt;
            default:   state_d = StFetch;
          endcase
        end else if (op_code == OP_BCOND) begin
          state_d = StBrCalc;
        end else begin
          state_d = StFetch;
        end
      end
      StExecR: begin
        alua_s     = ALUA_RSRC;
        alub_s     = ALUB_RDEST;
        alu_out_en = 1'b1;
        psr_en     = 1'b1;
        state_d    = (op_ext == EXT_CMP) ? StFetch : StWbAlu;
      end
      StExecI: begin
        alua_s  = ALUA_IMM;
        alub_s  = ALUB_RDEST;
        se_sign = is_signed_imm(op_code);
        if (op_code == OP_MOVI) begin
          // MOVI writes the zero-extended immediate directly.
          reg_wr  = 1'b1;
          wd_s    = WD_IMM;
          state_d = StFetch;
        end else begin
          alu_out_en = 1'b1;
          psr_en     = 1'b1;
          state_d    = (op_code == OP_CMPI) ? StFetch : StWbAlu;
        end
      end
      StWbAlu: begin
        reg_wr  = 1'b1;
        wd_s    = WD_ALU;
        state_d = StFetch;
      end
      StLoad: begin
        mem_s      = MEM_RDEST;
        mem_reg_en = 1'b1;
        state_d    = StLoadWb;
      end
      StLoadWb: begin
        reg_wr  = 1'b1;
        wd_s    = WD_MEM;
        state_d = StFetch;
      end
      StStore: begin
        mem_s   = MEM_RDEST;
        mem_we  = 1'b1;
        state_d = StFetch;
      end
      StBrCalc: begin
        alua_s     = ALUA_PC;
        alub_s     = ALUB_IMM;
        se_sign    = 1'b1;
        alu_out_en = 1'b1;
        state_d    = taken ? StBrTake : StFetch;
      end
      StBrTake: begin
        pc_en   = 1'b1;
        pc_s    = PC_ALU;
        state_d = StFetch;
      end
      StJump: begin
        pc_s    = PC_RSRC;
        pc_en   = taken;
        state_d = StFetch;
      end
      StHalt: begin
        halted  = 1'b1;
        state_d = StHalt;
      end
      default: state_d = StFetch;
    endcase
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: walks each instruction class
// cycle by cycle against hand-written control-word vectors.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] op_code, op_ext, cond;
  logic [4:0] psr_out;
  logic       pc_s, mem_s;
  logic [1:0] wd_s, alua_s, alub_s;
  logic       inst_en, alu_out_en, mem_reg_en, pc_en, psr_en, se_sign, reg_wr, mem_we, halted;
  logic [3:0] state;

  int tests = 0;
  int fails = 0;

  multicycle_controller dut (
    .clk        (clk),
    .reset      (reset),
    .op_code    (op_code),
    .op_ext     (op_ext),
    .cond       (cond),
    .psr_out    (psr_out),
    .pc_s       (pc_s),
    .mem_s      (mem_s),
    .wd_s       (wd_s),
    .alua_s     (alua_s),
    .alub_s     (alub_s),
    .inst_en    (inst_en),
    .alu_out_en (alu_out_en),
    .mem_reg_en (mem_reg_en),
    .pc_en      (pc_en),
    .psr_en     (psr_en),
    .se_sign    (se_sign),
    .reg_wr     (reg_wr),
    .mem_we     (mem_we),
    .halted     (halted),
    .state      (state)
  );

  always #5 clk = ~clk;

  // Word: {state, pc_s, mem_s, wd_s, alua_s, alub_s,
  //        inst_en, alu_out_en, mem_reg_en, pc_en, psr_en, se_sign, reg_wr, mem_we, halted}
  localparam logic [20:0] E_RESET   = {4'd0, 1'b0, 1'b1, 2'd0, 2'd1, 2'd2, 9'b100000000};
  localparam logic [20:0] E_FETCH   = {4'd0, 1'b0, 1'b1, 2'd0, 2'd1, 2'd2, 9'b110000000};
  localparam logic [20:0] E_DECODE  = {4'd1, 1'b1, 1'b0, 2'd0, 2'd0, 2'd0, 9'b000100000};
  localparam logic [20:0] E_EXEC_R  = {4'd2, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 9'b010010000};
  localparam logic [20:0] E_EXEC_I  = {4'd3, 1'b0, 1'b0, 2'd0, 2'd2, 2'd0, 9'b010010000};
  localparam logic [20:0] E_EXEC_IS = {4'd3, 1'b0, 1'b0, 2'd0, 2'd2, 2'd0, 9'b010011000};
  localparam logic [20:0] E_MOVI    = {4'd3, 1'b0, 1'b0, 2'd0, 2'd2, 2'd0, 9'b000000100};
  localparam logic [20:0] E_WB_ALU  = {4'd4, 1'b0, 1'b0, 2'd3, 2'd0, 2'd0, 9'b000000100};
  localparam logic [20:0] E_LOAD    = {4'd5, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 9'b001000000};
  localparam logic [20:0] E_LOAD_WB = {4'd6, 1'b0, 1'b0, 2'd2, 2'd0, 2'd0, 9'b000000100};
  localparam logic [20:0] E_STORE   = {4'd7, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 9'b000000010};
  localparam logic [20:0] E_BR_CALC = {4'd8, 1'b0, 1'b0, 2'd0, 2'd1, 2'd1, 9'b010001000};
  localparam logic [20:0] E_BR_TAKE = {4'd9, 1'b1, 1'b0, 2'd0, 2'd0, 2'd0, 9'b000100000};
  localparam logic [20:0] E_JUMP_T  = {4'd10, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 9'b000100000};
  localparam logic [20:0] E_JUMP_N  = {4'd10, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 9'b000000000};
  localparam logic [20:0] E_HALT    = {4'd11, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 9'b000000001};

  function automatic logic [20:0] outs();
    return {state, pc_s, mem_s, wd_s, alua_s, alub_s, inst_en, alu_out_en, mem_reg_en, pc_en,
            psr_en, se_sign, reg_wr, mem_we, halted};
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    op_code = 4'd0; op_ext = 4'd0; cond = 4'd0; psr_out = 5'd0;
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if (outs() !== E_RESET) begin
      fails++;
      $display("FAIL reset_held got %h exp %h", outs(), E_RESET);
    end
    reset = 1'b0;
    #1;
    tests++;
    if (outs() !== E_FETCH) begin
      fails++;
      $display("FAIL reset_release got %h exp %h", outs(), E_FETCH);
    end
  endtask

  task automatic test_add();
    logic [20:0] seq [5];
    seq = '{E_FETCH, E_DECODE, E_EXEC_R, E_WB_ALU, E_FETCH};
    op_code = 4'b0000; op_ext = 4'b0101;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) begin @(posedge clk); #1; end
      tests++;
      if (outs() !== seq[i]) begin
        fails++;
        $display("FAIL add cyc%0d got %h exp %h", i + 1, outs(), seq[i]);
      end
    end
  endtask

  task automatic test_compare();
    logic [20:0] seq [4];
    logic [3:0]  ops [2];
    logic [3:0]  exts [2];
    ops  = '{4'b0000, 4'b1011};
    exts = '{4'b1011, 4'b0000};
    for (int k = 0; k < 2; k++) begin
      op_code = ops[k]; op_ext = exts[k];
      seq = '{E_FETCH, E_DECODE, (k == 0) ? E_EXEC_R : E_EXEC_IS, E_FETCH};
      for (int i = 0; i < 4; i++) begin
        if (i > 0) begin @(posedge clk); #1; end
        tests++;
        if (outs() !== seq[i]) begin
          fails++;
          $display("FAIL cmp%0d cyc%0d got %h exp %h", k, i + 1, outs(), seq[i]);
        end
      end
    end
  endtask

  task automatic test_imm();
    logic [20:0] seq [5];
    // ORI: zero-extended immediate, writes back through alu_out
    op_code = 4'b0010; op_ext = 4'b0000;
    seq = '{E_FETCH, E_DECODE, E_EXEC_I, E_WB_ALU, E_FETCH};
    for (int i = 0; i < 5; i++) begin
      if (i > 0) begin @(posedge clk); #1; end
      tests++;
      if (outs() !== seq[i]) begin
        fails++;
        $display("FAIL ori cyc%0d got %h exp %h", i + 1, outs(), seq[i]);
      end
    end
    op_code = 4'b1101;
    seq = '{E_FETCH, E_DECODE, E_MOVI, E_FETCH, E_FETCH};
    for (int i = 0; i < 4; i++) begin
      if (i > 0) begin @(posedge clk); #1; end
      tests++;
      if (outs() !== seq[i]) begin
        fails++;
        $display("FAIL movi cyc%0d got %h exp %h", i + 1, outs(), seq[i]);
      end
    end
    op_code = 4'b0110;
    seq = '{E_FETCH, E_DECODE, E_FETCH, E_FETCH, E_FETCH};
    for (int i = 0; i < 3; i++) begin
      if (i > 0) begin @(posedge clk); #1; end
      tests++;
      if (outs() !== seq[i]) begin
        fails++;
        $display("FAIL nop cyc%0d got %h exp %h", i + 1, outs(), seq[i]);
      end
    end
  endtask

  task automatic test_load_store();
    logic [20:0] seq [5];
    op_code = 4'b0100; op_ext = 4'b0000;
    seq = '{E_FETCH, E_DECODE, E_LOAD, E_LOAD_WB, E_FETCH};
    for (int i = 0; i < 5; i++) begin
      if (i > 0) begin @(posedge clk); #1; end
      tests++;
      if (outs() !== seq[i]) begin
        fails++;
        $display("FAIL load cyc%0d got %h exp %h", i + 1, outs(), seq[i]);
      end
    end
    op_ext = 4'b0100;
    seq = '{E_FETCH, E_DECODE, E_STORE, E_FETCH, E_FETCH};
    for (int i = 0; i < 4; i++) begin
      if (i > 0) begin @(posedge clk); #1; end
      tests++;
      if (outs() !== seq[i]) begin
        fails++;
        $display("FAIL store cyc%0d got %h exp %h", i + 1, outs(), seq[i]);
      end
    end
  endtask

  task automatic test_branch();
    logic [20:0] seq [5];
    logic [3:0]  conds [4];
    logic [4:0]  psrs [4];
    logic        tk [4];
    conds = '{4'b0000, 4'b0000, 4'b1110, 4'b1111};
    psrs  = '{5'b01000, 5'b00000, 5'b00000, 5'b11111};
    tk    = '{1'b1, 1'b0, 1'b1, 1'b0};
    op_code = 4'b1100; op_ext = 4'b0000;
    for (int k = 0; k < 4; k++) begin
      cond = conds[k]; psr_out = psrs[k];
      if (tk[k]) seq = '{E_FETCH, E_DECODE, E_BR_CALC, E_BR_TAKE, E_FETCH};
      else       seq = '{E_FETCH, E_DECODE, E_BR_CALC, E_FETCH, E_FETCH};
      for (int i = 0; i < (tk[k] ? 5 : 4); i++) begin
        if (i > 0) begin @(posedge clk); #1; end
        tests++;
        if (outs() !== seq[i]) begin
          fails++;
          $display("FAIL branch%0d cyc%0d got %h exp %h", k, i + 1, outs(), seq[i]);
        end
      end
    end
  endtask

  task automatic test_jump();
    logic [20:0] seq [4];
    logic [3:0]  conds [12];
    logic [4:0]  psrs [12];
    logic        tk [12];
    conds = '{4'b0001, 4'b0001, 4'b0010, 4'b0011, 4'b0100, 4'b0101,
              4'b0110, 4'b0111, 4'b1000, 4'b1001, 4'b1010, 4'b1110};
    psrs  = '{5'b01000, 5'b00000, 5'b00001, 5'b00001, 5'b00010, 5'b00010,
              5'b10000, 5'b10000, 5'b00100, 5'b00100, 5'b11111, 5'b00000};
    tk    = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    op_code = 4'b0100; op_ext = 4'b1100;
    for (int k = 0; k < 12; k++) begin
      cond = conds[k]; psr_out = psrs[k];
      seq = '{E_FETCH, E_DECODE, tk[k] ? E_JUMP_T : E_JUMP_N, E_FETCH};
      for (int i = 0; i < 4; i++) begin
        if (i > 0) begin @(posedge clk); #1; end
        tests++;
        if (outs() !== seq[i]) begin
          fails++;
          $display("FAIL jump%0d cyc%0d got %h exp %h", k, i + 1, outs(), seq[i]);
        end
      end
    end
  endtask

  task automatic test_halt_and_reset();
    logic [20:0] seq [3];
    op_code = 4'b0100; op_ext = 4'b0001;
    seq = '{E_FETCH, E_DECODE, E_HALT};
    for (int i = 0; i < 23; i++) begin
      if (i > 0) begin @(posedge clk); #1; end
      tests++;
      if (outs() !== seq[(i < 2) ? i : 2]) begin
        fails++;
        $display("FAIL halt cyc%0d got %h exp %h", i + 1, outs(), seq[(i < 2) ? i : 2]);
      end
    end
    reset = 1'b1;
    #1;
    reset = 1'b0;
    #1;
    tests++;
    if (outs() !== E_FETCH) begin
      fails++;
      $display("FAIL halt_exit got %h exp %h", outs(), E_FETCH);
    end
    // Load, then pull reset while in LOAD_WB
    op_ext = 4'b0000;
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if (outs() !== E_LOAD_WB) begin
      fails++;
      $display("FAIL pre_abort got %h exp %h", outs(), E_LOAD_WB);
    end
    reset = 1'b1;
    op_code = 4'b0110;
    #1;
    tests++;
    if (outs() !== E_RESET) begin
      fails++;
      $display("FAIL abort_reset got %h exp %h", outs(), E_RESET);
    end
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      tests++;
      if (reg_wr !== 1'b0 || mem_we !== 1'b0) begin
        fails++;
        $display("FAIL post_abort cyc%0d got reg_wr=%b mem_we=%b exp 0 0", i, reg_wr, mem_we);
      end
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_compare();
    test_imm();
    test_load_store();
    test_branch();
    test_jump();
    test_halt_and_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
